// File: rtl/layer_output_packer_pkg.sv
// Shared constants, field helpers and FSM encoding for the layer output packer.
// Widths are derived from the data word width n through constant functions.
package layer_output_packer_pkg;

    localparam int N_DEFAULT = 8;

    // Full MAC sum width: sign bit plus magnitude.
    function automatic int res_width(input int n_w);
        return 3 * n_w - 3;
    endfunction

    function automatic int mag_width(input int n_w);
        return 3 * n_w - 4;
    endfunction

    // Bit position of the sign in a MAC sum.
    function automatic int res_sign_pos(input int n_w);
        return 3 * n_w - 4;
    endfunction

    // Bit position of the sign in a packed data word.
    function automatic int word_sign_pos(input int n_w);
        return n_w - 1;
    endfunction

    // Largest magnitude representable in an n-bit sign-magnitude word.
    function automatic int max_mag(input int n_w);
        return (1 << (n_w - 1)) - 1;
    endfunction

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/layer_output_packer_if.sv
// Handshake bundle between MAC sums, the packer and the next layer's data input.
interface layer_output_packer_if
    import layer_output_packer_pkg::*;
#(
    parameter int n                 = 8,
    parameter int number_of_outputs = 62
);
    logic [res_width(n)-1:0]          res;
    logic                             res_valid;
    logic                             res_ready;
    logic [number_of_outputs*n-1:0]   data_out;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        output res, res_valid, out_ready,
        input  res_ready, data_out, out_valid
    );

    modport slave (
        input  res, res_valid, out_ready,
        output res_ready, data_out, out_valid
    );
endinterface

// File: rtl/layer_output_packer_sm_requant.sv
// Combinational requantizer: round, shift, saturate and optionally ReLU a wide
// sign-magnitude MAC sum down to an n-bit sign-magnitude word.
module sm_requant
    import layer_output_packer_pkg::*;
#(
    parameter int n     = 8,
    parameter int SHIFT = 7,
    parameter int RELU  = 1
) (
    input  logic [res_width(n)-1:0] res,
    output logic [n-1:0]            q
);
    localparam int RW = res_width(n);
    localparam int MW = mag_width(n);
    localparam logic [RW-1:0] RND  = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [RW-1:0] MAXM = RW'(max_mag(n));

    logic [RW-1:0] m_s;
    logic [n-2:0]  mag_sat_s;
    logic          sign_s;

    // Round-half-up on the magnitude, drop SHIFT bits, then clamp and apply sign rules.
    always_comb begin
        sign_s = res[res_sign_pos(n)];
        m_s    = ({1'b0, res[MW-1:0]} + RND) >> SHIFT;
        if (m_s > MAXM) begin
            mag_sat_s = MAXM[n-2:0];
        end else begin
            mag_sat_s = m_s[n-2:0];
        end
        if (sign_s && (RELU != 0)) begin
            q = {n{1'b0}};
        end else if (mag_sat_s == {(n-1){1'b0}}) begin
            q = {n{1'b0}};
        end else begin
            q = {sign_s, mag_sat_s};
        end
    end
endmodule

// File: rtl/layer_output_packer.sv
// Collects requantized neuron sums into a packed layer vector and hands the
// complete vector downstream with a valid/ready handshake.
module layer_output_packer
    import layer_output_packer_pkg::*;
#(
    parameter int n                 = 8,
    parameter int number_of_outputs = 62,
    parameter int SHIFT             = 7,
    parameter int RELU              = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    layer_output_packer_if.slave  bus
);
    localparam int IW = (number_of_outputs > 1) ? $clog2(number_of_outputs) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(number_of_outputs - 1);

    state_t                          state_r;
    logic [IW-1:0]                   idx_r;
    logic [number_of_outputs*n-1:0]  data_r;
    logic                            out_valid_r;
    logic                            res_ready_r;
    logic [n-1:0]                    q_s;

    sm_requant #(
        .n     (n),
        .SHIFT (SHIFT),
        .RELU  (RELU)
    ) u_requant (
        .res (bus.res),
        .q   (q_s)
    );

    // Packer FSM: fill slots in acceptance order, then hold the vector until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= COLLECT;
            idx_r       <= {IW{1'b0}};
            data_r      <= {(number_of_outputs*n){1'b0}};
            out_valid_r <= 1'b0;
            res_ready_r <= 1'b1;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (bus.res_valid) begin
                        data_r[idx_r*n +: n] <= q_s;
                        if (idx_r == LAST_IDX) begin
                            idx_r       <= {IW{1'b0}};
                            state_r     <= FULL;
                            out_valid_r <= 1'b1;
                            res_ready_r <= 1'b0;
                        end else begin
                            idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                FULL: begin
                    // Release returns to COLLECT only; the freed cycle accepts nothing.
                    if (bus.out_ready) begin
                        state_r     <= COLLECT;
                        out_valid_r <= 1'b0;
                        res_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= COLLECT;
                    idx_r       <= {IW{1'b0}};
                    out_valid_r <= 1'b0;
                    res_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_out  = data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.res_ready = res_ready_r;
endmodule
